// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter: round-robin arbiter sharing one single-port memory between
// the instruction-fetch (IF) and load/store (D) requesters.
module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_done_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_done_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_wr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              last_grant_o
);

  localparam int               CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q;
  logic              gnt_q;
  logic              we_q;
  logic              last_grant_q;
  logic              busy_q;
  logic              mem_wr_q;
  logic              if_done_q;
  logic              d_done_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              grant_d;

  // On a tie the requester that was not granted last wins (1 = D).
  always_comb begin
    grant_d = d_req_i;
    if (if_req_i && d_req_i) begin
      grant_d = ~last_grant_q;
    end
  end

  // mem_addr_q / mem_wdata_q double as the latched command; they read 0 in IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
      mem_wr_q     <= 1'b0;
      if_done_q    <= 1'b0;
      d_done_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      cnt_q        <= '0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (if_req_i || d_req_i) begin
            state_q      <= S_ISSUE;
            busy_q       <= 1'b1;
            gnt_q        <= grant_d;
            last_grant_q <= grant_d;
            if (grant_d) begin
              mem_addr_q  <= d_addr_i;
              mem_wdata_q <= d_wdata_i;
              we_q        <= d_we_i;
              mem_wr_q    <= d_we_i;
            end else begin
              mem_addr_q  <= if_addr_i;
              mem_wdata_q <= '0;
              we_q        <= 1'b0;
              mem_wr_q    <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          mem_wr_q <= 1'b0;
          if (we_q || MEM_LAT == 1) begin
            state_q   <= S_DONE;
            if_done_q <= ~gnt_q;
            d_done_q  <= gnt_q;
          end else begin
            state_q <= S_WAIT;
          end
          cnt_q <= CNT_ONE;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_q   <= S_DONE;
            if_done_q <= ~gnt_q;
            d_done_q  <= gnt_q;
          end
        end
        default: begin
          // Read data is valid in the DONE cycle; capture it on the closing edge.
          if (!we_q) begin
            if (gnt_q) begin
              d_rdata_q <= mem_rdata_i;
            end else begin
              if_rdata_q <= mem_rdata_i;
            end
          end
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          we_q        <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          cnt_q       <= '0;
        end
      endcase
    end
  end

  assign if_done_o    = if_done_q;
  assign d_done_o     = d_done_q;
  assign if_rdata_o   = if_rdata_q;
  assign d_rdata_o    = d_rdata_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_wr_o     = mem_wr_q;
  assign busy_o       = busy_q;
  assign last_grant_o = last_grant_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// tb_mem_port_arbiter: two arbiter instances (MEM_LAT 2 and 4) against a
// transaction-level model plus directed hand-computed checks.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmp_on = 1'b0;
  logic        mem_ready = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic        if_req   [2];
  logic [63:0] if_addr  [2];
  logic        d_req    [2];
  logic        d_we     [2];
  logic [63:0] d_addr   [2];
  logic [63:0] d_wdata  [2];
  logic        if_done  [2];
  logic        d_done   [2];
  logic [63:0] if_rdata [2];
  logic [63:0] d_rdata  [2];
  logic [63:0] mem_addr [2];
  logic [63:0] mem_wdata[2];
  logic        mem_wr   [2];
  logic [63:0] mem_rdata[2];
  logic        busy     [2];
  logic        last_grant[2];

  logic [63:0] mem  [2][512];
  logic [8:0]  hist [2][4];

  // Transaction-level model state.
  logic        m_act  [2];
  int          m_ph   [2];
  logic        m_gnt  [2];
  logic        m_we   [2];
  logic        m_last [2];
  logic [63:0] m_addr [2];
  logic [63:0] m_wdata[2];
  logic [63:0] m_ifr  [2];
  logic [63:0] m_dr   [2];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req[0]), .if_addr_i(if_addr[0]),
    .if_done_o(if_done[0]), .if_rdata_o(if_rdata[0]),
    .d_req_i(d_req[0]), .d_we_i(d_we[0]), .d_addr_i(d_addr[0]), .d_wdata_i(d_wdata[0]),
    .d_done_o(d_done[0]), .d_rdata_o(d_rdata[0]),
    .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]), .mem_wr_o(mem_wr[0]),
    .mem_rdata_i(mem_rdata[0]), .busy_o(busy[0]), .last_grant_o(last_grant[0])
  );

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(4)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req[1]), .if_addr_i(if_addr[1]),
    .if_done_o(if_done[1]), .if_rdata_o(if_rdata[1]),
    .d_req_i(d_req[1]), .d_we_i(d_we[1]), .d_addr_i(d_addr[1]), .d_wdata_i(d_wdata[1]),
    .d_done_o(d_done[1]), .d_rdata_o(d_rdata[1]),
    .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]), .mem_wr_o(mem_wr[1]),
    .mem_rdata_i(mem_rdata[1]), .busy_o(busy[1]), .last_grant_o(last_grant[1])
  );

  // Memory returns the word at the address presented MEM_LAT cycles earlier.
  assign mem_rdata[0] = mem[0][hist[0][1]];
  assign mem_rdata[1] = mem[1][hist[1][3]];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 512; i++) begin
          mem[k][i] <= (i == 256) ? 64'hDEAD : (64'hC0DE_0000_0000_0000 | 64'(i));
        end
        for (int j = 0; j < 4; j++) hist[k][j] <= 9'd0;
      end
      mem_ready <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (mem_wr[k]) mem[k][mem_addr[k][8:0]] <= mem_wdata[k];
        hist[k][0] <= mem_addr[k][8:0];
        for (int j = 1; j < 4; j++) hist[k][j] <= hist[k][j-1];
      end
    end
  end

  function automatic int txn_len(input int k, input logic we);
    return we ? 2 : 1 + ((k == 1) ? 4 : 2);
  endfunction

  function automatic logic pick(input int k);
    return (if_req[k] && d_req[k]) ? ~m_last[k] : d_req[k];
  endfunction

  // A transaction occupies phases 1..len after the IDLE cycle that granted it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k] <= 1'b0;  m_ph[k] <= 0;     m_gnt[k] <= 1'b0; m_we[k] <= 1'b0;
        m_last[k] <= 1'b1; m_addr[k] <= '0;  m_wdata[k] <= '0;
        m_ifr[k] <= '0;    m_dr[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!m_act[k]) begin
          if (if_req[k] || d_req[k]) begin
            m_act[k]   <= 1'b1;
            m_ph[k]    <= 1;
            m_gnt[k]   <= pick(k);
            m_last[k]  <= pick(k);
            m_we[k]    <= pick(k) ? d_we[k] : 1'b0;
            m_addr[k]  <= pick(k) ? d_addr[k] : if_addr[k];
            m_wdata[k] <= pick(k) ? d_wdata[k] : 64'd0;
          end
        end else if (m_ph[k] == txn_len(k, m_we[k])) begin
          m_act[k] <= 1'b0;
          m_ph[k]  <= 0;
          if (!m_we[k]) begin
            if (m_gnt[k]) m_dr[k] <= mem[k][m_addr[k][8:0]];
            else          m_ifr[k] <= mem[k][m_addr[k][8:0]];
          end
        end else begin
          m_ph[k] <= m_ph[k] + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int k = 0; k < 2; k++) begin
        chk("cmp_busy",      64'(busy[k]),       64'(m_act[k]));
        chk("cmp_last_grant",64'(last_grant[k]), 64'(m_last[k]));
        chk("cmp_mem_addr",  mem_addr[k],        m_act[k] ? m_addr[k] : 64'd0);
        chk("cmp_mem_wdata", mem_wdata[k],       m_act[k] ? m_wdata[k] : 64'd0);
        chk("cmp_mem_wr",    64'(mem_wr[k]),     64'(m_act[k] && m_we[k] && m_ph[k] == 1));
        chk("cmp_if_done",   64'(if_done[k]),
            64'(m_act[k] && !m_gnt[k] && m_ph[k] == txn_len(k, m_we[k])));
        chk("cmp_d_done",    64'(d_done[k]),
            64'(m_act[k] && m_gnt[k] && m_ph[k] == txn_len(k, m_we[k])));
        chk("cmp_if_rdata",  if_rdata[k],        m_ifr[k]);
        chk("cmp_d_rdata",   d_rdata[k],         m_dr[k]);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 1'b0; if_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_addr[k] = '0;   d_wdata[k] = '0;
    end
    repeat (3) step();
    chk("rst_busy", 64'(busy[0]), 64'd0);
    chk("rst_last_grant", 64'(last_grant[0]), 64'd1);
    chk("rst_mem_addr", mem_addr[0], 64'd0);
    #2 rst_n = 1'b1;
    cmp_on = 1'b1;
    step();

    // Tie right after reset: IF first, then D after one IDLE cycle.
    if_req[0] = 1'b1; if_addr[0] = 64'h100;
    d_req[0] = 1'b1;  d_we[0] = 1'b0; d_addr[0] = 64'h80; d_wdata[0] = 64'h0;
    chk("A_lg_reset", 64'(last_grant[0]), 64'd1);
    step();
    chk("A_lg_if", 64'(last_grant[0]), 64'd0);
    chk("A_addr_t1", mem_addr[0], 64'h100);
    step();
    chk("A_addr_t2", mem_addr[0], 64'h100);
    chk("A_ifdone_t2", 64'(if_done[0]), 64'd0);
    step();
    chk("A_addr_t3", mem_addr[0], 64'h100);
    chk("A_ifdone_t3", 64'(if_done[0]), 64'd1);
    chk("A_ddone_t3", 64'(d_done[0]), 64'd0);
    if_req[0] = 1'b0;
    step();
    chk("A_idle_busy", 64'(busy[0]), 64'd0);
    chk("A_idle_addr", mem_addr[0], 64'd0);
    chk("A_if_rdata", if_rdata[0], 64'hDEAD);
    step();
    chk("A_lg_d", 64'(last_grant[0]), 64'd1);
    chk("A_addr_d", mem_addr[0], 64'h80);
    step();
    step();
    chk("A_ddone", 64'(d_done[0]), 64'd1);
    d_req[0] = 1'b0;
    step();
    chk("A_d_rdata", d_rdata[0], 64'hC0DE_0000_0000_0080);

    // D store: single write strobe, done two cycles after request.
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 64'h40; d_wdata[0] = 64'h1234;
    step();
    chk("B_wr_on", 64'(mem_wr[0]), 64'd1);
    chk("B_addr", mem_addr[0], 64'h40);
    chk("B_wdata", mem_wdata[0], 64'h1234);
    chk("B_ddone_early", 64'(d_done[0]), 64'd0);
    step();
    chk("B_wr_off", 64'(mem_wr[0]), 64'd0);
    chk("B_ddone", 64'(d_done[0]), 64'd1);
    d_req[0] = 1'b0; d_we[0] = 1'b0;
    step();
    chk("B_d_rdata_kept", d_rdata[0], 64'hC0DE_0000_0000_0080);

    // Address change after grant must not reach the memory port.
    d_req[0] = 1'b1; d_addr[0] = 64'h40; d_wdata[0] = 64'h0;
    step();
    d_addr[0] = 64'h80;
    chk("C_addr_issue", mem_addr[0], 64'h40);
    step();
    chk("C_addr_wait", mem_addr[0], 64'h40);
    step();
    chk("C_addr_done", mem_addr[0], 64'h40);
    chk("C_ddone", 64'(d_done[0]), 64'd1);
    d_req[0] = 1'b0;
    step();
    chk("C_d_rdata", d_rdata[0], 64'h1234);

    // Both held continuously: six alternating grants starting with IF.
    if_req[0] = 1'b1; if_addr[0] = 64'h100;
    d_req[0] = 1'b1;  d_we[0] = 1'b0; d_addr[0] = 64'h8;
    n = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      step();
      if (if_done[0] || d_done[0]) begin
        chk("D_rr_order", 64'(d_done[0]), 64'(n % 2));
        n++;
        if (n == 6) begin
          if_req[0] = 1'b0; d_req[0] = 1'b0;
        end
      end
    end
    chk("D_rr_count", 64'(n), 64'd6);
    step();
    chk("D_d_rdata", d_rdata[0], 64'hC0DE_0000_0000_0008);

    // MEM_LAT=4 instance: reset during WAIT, then full-latency re-service.
    if_req[1] = 1'b1; if_addr[1] = 64'h100;
    step();
    step();
    step();
    chk("E_busy_wait", 64'(busy[1]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("E_rst_busy", 64'(busy[1]), 64'd0);
    chk("E_rst_addr", mem_addr[1], 64'd0);
    chk("E_rst_lg", 64'(last_grant[1]), 64'd1);
    chk("E_rst_ifdone", 64'(if_done[1]), 64'd0);
    step();
    step();
    chk("E_rst_nodone", 64'(if_done[1]), 64'd0);
    #2 rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("E_ifdone_early", 64'(if_done[1]), 64'd0);
    end
    step();
    chk("E_ifdone_t5", 64'(if_done[1]), 64'd1);
    if_req[1] = 1'b0;
    step();
    chk("E_if_rdata", if_rdata[1], 64'hDEAD);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between two requesters: the instruction-fetch path (IF) and the load/store data path (D).
- Each requester runs a req/done handshake. The arbiter runs a small FSM that grants one requester at a time, latches its command, drives the memory port, waits the fixed read latency and returns the read data.
- It sits between the control-unit-driven datapath and the shared memory.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- MEM_LAT, 2, cycles from first presentation of mem_addr to valid mem_rdata. Legal range is ≥1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- if_req  in  1  IF request, held until if_done.
- if_addr  in  ADDR_W  IF read address.
- if_done  out  1  one-cycle completion pulse to IF.
- if_rdata  out  DATA_W  registered IF read data.
- d_req  in  1  D request, held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  D address.
- d_wdata  in  DATA_W  D store data.
- d_done  out  1  one-cycle completion pulse to D.
- d_rdata  out  DATA_W  registered D load data.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wr  out  1  memory write strobe.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  1 in any state other than IDLE.
- last_grant  out  1  0 = IF granted last, 1 = D granted last.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State = IDLE.
  - All outputs 0, except last_grant = 1.
  - Latched command and latency counter cleared.
  - if_rdata and d_rdata = 0.
  - Any in-flight transaction is abandoned and no done pulse is generated.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - mem_addr = 0, mem_wdata = 0, mem_wr = 0, busy = 0.
  - If only one req is high, grant it.
  - If both are high, grant the requester opposite last_grant (round-robin). After reset IF wins the first tie.
  - On grant, latch addr, wdata and we (IF: we = 0, wdata = 0) and the grant id, update last_grant, and go to ISSUE.
  - No req: stay in IDLE.
- ISSUE (1 cycle):
  - mem_addr and mem_wdata are driven from the latched values; they stay stable through WAIT.
  - Write: mem_wr = 1 for this cycle only, then go to DONE.
  - Read: mem_wr = 0, counter loads 1, then:
    - MEM_LAT = 1 → DONE.
    - MEM_LAT > 1 → WAIT.
- WAIT:
  - Counter increments each cycle.
  - When the counter reaches MEM_LAT − 1, go to DONE next cycle.
  - Counter width = clog2(MEM_LAT + 1).
- DONE (1 cycle):
  - mem_addr is still driven.
  - Pulse the granted requester's done.
  - For a read, capture mem_rdata into that requester's rdata register on this edge, so rdata is valid from the cycle after the done pulse and holds until the next read for that requester.
  - The other requester's done stays 0.
  - Next state IDLE.
- Latency from req sampled in IDLE at cycle t:
  - Read: done at cycle t + 1 + MEM_LAT.
  - Write: done at cycle t + 2.
- Requester rules:
  - Requester keeps req, addr, wdata and we stable until done.
  - Requester deasserts req on the edge after done. A req still high in the following IDLE cycle is a new request.
  - Input changes after grant are ignored, because the command is latched.
- Losing requester:
  - Its req stays pending with no done pulse.
  - It is served in the next IDLE cycle.
  - Starvation is bounded to one transaction.
- Back-to-back transactions: at least one IDLE cycle between consecutive transactions.
- if_done and d_done are never high together. Neither is ever high outside DONE.

Test Plan:
- MEM_LAT = 2, if_req = 1, if_addr = 0x100, memory returns 0xDEAD at 0x100 → mem_addr = 0x100 for 3 cycles; if_done pulses at t + 3; if_rdata = 0xDEAD from t + 4.
- d_req = 1, d_we = 1, d_addr = 0x40, d_wdata = 0x1234 → mem_wr high for exactly one cycle with mem_addr = 0x40 and mem_wdata = 0x1234; d_done at t + 2; d_rdata unchanged.
- Right after reset, if_req and d_req rise together (D load 0x80) → IF served first (last_grant = 0); D granted in the next IDLE; d_done follows if_done with exactly one IDLE cycle between.
- Both reqs held continuously for 6 transactions → grants alternate IF, D, IF, D, IF, D; done pulses alternate; never both high.
- MEM_LAT = 4, reset asserted during WAIT → all outputs 0 immediately; no done pulse; after release, a still-held req is re-served from IDLE with full latency (done at t + 5).
- d_addr changed from 0x40 to 0x80 one cycle after grant → mem_addr stays 0x40 for the whole transaction.
